// File: rtl/riscv_seq_ctrl.sv
// Multi-cycle sequencer for the NPC core: IFU/LSU handshakes, IR/PC/regfile strobes,
// retire counting, and sticky halt on ebreak, illegal instruction or bus timeout.
//
//   state      | meaning
//   IF_REQ     | fetch request valid, waiting for IFU ready
//   IF_WAIT    | waiting for fetched instruction, latch IR on rvalid
//   EX         | decoder outputs stable, choose mem / writeback / halt
//   MEM_REQ    | data request valid, waiting for LSU ready
//   MEM_WAIT   | waiting for load data / store ack
//   WB         | write rd, update PC, retire (single cycle)
//   HALT       | stopped until rst, err_code holds the cause

module riscv_seq_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    input  logic             ifu_rvalid,
    output logic             inst_we,
    input  logic             dec_RegWr,
    input  logic             dec_MemtoReg,
    input  logic             dec_MemWr,
    input  logic             dec_illegal,
    input  logic             dec_ebreak,
    output logic             lsu_req_valid,
    output logic             lsu_req_wen,
    input  logic             lsu_req_ready,
    input  logic             lsu_rvalid,
    output logic             rf_we,
    output logic             pc_we,
    output logic             retire,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] minstret
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] ERR_EBREAK  = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_IFU_TO  = 2'b10;
    localparam logic [1:0] ERR_LSU_TO  = 2'b11;

    typedef enum logic [2:0] {
        S_IF_REQ   = 3'd0,
        S_IF_WAIT  = 3'd1,
        S_EX       = 3'd2,
        S_MEM_REQ  = 3'd3,
        S_MEM_WAIT = 3'd4,
        S_WB       = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [CNT_W-1:0]  minstret_q, minstret_d;
    logic              halted_q, halted_d;
    logic [1:0]        err_q, err_d;

    logic              wd_expired;
    logic              bus_state;

    assign wd_expired = (TIMEOUT != 0) && (wdog_q == WD_LAST);

    assign bus_state = (state_q == S_IF_REQ)  || (state_q == S_IF_WAIT) ||
                       (state_q == S_MEM_REQ) || (state_q == S_MEM_WAIT);

    // Handshake is tested before the watchdog so a same-cycle completion wins.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        minstret_d = minstret_q;
        case (state_q)
            S_IF_REQ: begin
                if (ifu_req_ready) begin
                    state_d = S_IF_WAIT;
                end else if (wd_expired) begin
                    state_d = S_HALT;
                    err_d   = ERR_IFU_TO;
                end
            end
            S_IF_WAIT: begin
                if (ifu_rvalid) begin
                    state_d = S_EX;
                end else if (wd_expired) begin
                    state_d = S_HALT;
                    err_d   = ERR_IFU_TO;
                end
            end
            S_EX: begin
                if (dec_illegal) begin
                    state_d = S_HALT;
                    err_d   = ERR_ILLEGAL;
                end else if (dec_ebreak) begin
                    state_d = S_HALT;
                    err_d   = ERR_EBREAK;
                end else if (dec_MemtoReg || dec_MemWr) begin
                    state_d = S_MEM_REQ;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM_REQ: begin
                if (lsu_req_ready) begin
                    state_d = S_MEM_WAIT;
                end else if (wd_expired) begin
                    state_d = S_HALT;
                    err_d   = ERR_LSU_TO;
                end
            end
            S_MEM_WAIT: begin
                if (lsu_rvalid) begin
                    state_d = S_WB;
                end else if (wd_expired) begin
                    state_d = S_HALT;
                    err_d   = ERR_LSU_TO;
                end
            end
            S_WB: begin
                minstret_d = minstret_q + CNT_W'(1);
                state_d    = S_IF_REQ;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IF_REQ;
            end
        endcase
    end

    always_comb begin
        halted_d = halted_q || (state_d == S_HALT);
        if ((state_d != state_q) || !bus_state) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IF_REQ;
            wdog_q     <= '0;
            minstret_q <= '0;
            halted_q   <= 1'b0;
            err_q      <= ERR_EBREAK;
        end else begin
            state_q    <= state_d;
            wdog_q     <= wdog_d;
            minstret_q <= minstret_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
        end
    end

    // Strobes decode from the registered state; rst masks them while it is held.
    assign ifu_req_valid = !rst && (state_q == S_IF_REQ);
    assign inst_we       = !rst && (state_q == S_IF_WAIT) && ifu_rvalid;
    assign lsu_req_valid = !rst && (state_q == S_MEM_REQ);
    assign lsu_req_wen   = lsu_req_valid && dec_MemWr;
    assign rf_we         = !rst && (state_q == S_WB) && dec_RegWr;
    assign pc_we         = !rst && (state_q == S_WB);
    assign retire        = !rst && (state_q == S_WB);

    assign halted   = halted_q;
    assign err_code = err_q;
    assign minstret = minstret_q;

endmodule

// File: tb/tb_riscv_seq_ctrl.sv
// Directed bench for riscv_seq_ctrl (CNT_W=4 for a short wrap, TIMEOUT=8).

module tb_riscv_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       ifu_req_valid, ifu_req_ready, ifu_rvalid, inst_we;
    logic       dec_RegWr, dec_MemtoReg, dec_MemWr, dec_illegal, dec_ebreak;
    logic       lsu_req_valid, lsu_req_wen, lsu_req_ready, lsu_rvalid;
    logic       rf_we, pc_we, retire, halted;
    logic [1:0] err_code;
    logic [3:0] minstret;

    int n_cmp;
    int n_err;

    logic [9:0] t2_rdy, t2_rv, t2_val, t2_ret;

    riscv_seq_ctrl #(.CNT_W(4), .TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_rvalid    (ifu_rvalid),
        .inst_we       (inst_we),
        .dec_RegWr     (dec_RegWr),
        .dec_MemtoReg  (dec_MemtoReg),
        .dec_MemWr     (dec_MemWr),
        .dec_illegal   (dec_illegal),
        .dec_ebreak    (dec_ebreak),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_wen   (lsu_req_wen),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rvalid    (lsu_rvalid),
        .rf_we         (rf_we),
        .pc_we         (pc_we),
        .retire        (retire),
        .halted        (halted),
        .err_code      (err_code),
        .minstret      (minstret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        ifu_req_ready = 1'b0; ifu_rvalid = 1'b0;
        lsu_req_ready = 1'b0; lsu_rvalid = 1'b0;
        dec_RegWr = 1'b0; dec_MemtoReg = 1'b0; dec_MemWr = 1'b0;
        dec_illegal = 1'b0; dec_ebreak = 1'b0;

        // reset state: every strobe low while rst is held
        next(); next(); #1;
        chk("rst_ifu_valid", ifu_req_valid, 0);
        chk("rst_lsu_valid", lsu_req_valid, 0);
        chk("rst_pc_we",     pc_we, 0);
        chk("rst_retire",    retire, 0);
        chk("rst_halted",    halted, 0);
        chk("rst_err",       err_code, 0);
        chk("rst_minstret",  minstret, 0);

        // 1: ALU ops with zero-wait bus, retire every 4th cycle
        rst = 1'b0;
        ifu_req_ready = 1'b1; ifu_rvalid = 1'b1;
        lsu_req_ready = 1'b1; lsu_rvalid = 1'b1;
        dec_RegWr = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk("alu_ifu_valid", ifu_req_valid, (c % 4) == 0);
            chk("alu_inst_we",   inst_we,       (c % 4) == 1);
            chk("alu_rf_we",     rf_we,         (c % 4) == 3);
            chk("alu_pc_we",     pc_we,         (c % 4) == 3);
            chk("alu_retire",    retire,        (c % 4) == 3);
            chk("alu_lsu_valid", lsu_req_valid, 0);
            next();
        end
        #1;
        chk("alu_minstret3", minstret, 3);

        // 2: load, ready on third MEM_REQ cycle, rvalid on third MEM_WAIT cycle
        dec_MemtoReg = 1'b1;
        t2_rdy = 10'b0000100000;
        t2_rv  = 10'b0100000000;
        t2_val = 10'b0000111000;
        t2_ret = 10'b1000000000;
        for (int c = 0; c < 10; c++) begin
            lsu_req_ready = t2_rdy[c];
            lsu_rvalid    = t2_rv[c];
            #1;
            chk("ld_lsu_valid", lsu_req_valid, t2_val[c]);
            chk("ld_lsu_wen",   lsu_req_wen,   0);
            chk("ld_retire",    retire,        t2_ret[c]);
            if (c == 9) chk("ld_rf_we", rf_we, 1);
            next();
        end
        #1;
        chk("ld_back_ifreq", ifu_req_valid, 1);
        chk("ld_minstret4",  minstret, 4);

        // 3: store, no register write
        dec_RegWr = 1'b0; dec_MemtoReg = 1'b0; dec_MemWr = 1'b1;
        lsu_req_ready = 1'b1; lsu_rvalid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("st_lsu_valid", lsu_req_valid, c == 3);
            chk("st_lsu_wen",   lsu_req_wen,   c == 3);
            chk("st_rf_we",     rf_we,         0);
            chk("st_pc_we",     pc_we,         c == 5);
            chk("st_retire",    retire,        c == 5);
            next();
        end
        #1;
        chk("st_minstret5", minstret, 5);

        // 6: reset while a load sits in MEM_WAIT
        dec_MemWr = 1'b0; dec_MemtoReg = 1'b1; dec_RegWr = 1'b1;
        lsu_rvalid = 1'b0;
        repeat (4) next();
        #1;
        chk("mrst_pre_valid",    lsu_req_valid, 0);
        chk("mrst_pre_minstret", minstret, 5);
        rst = 1'b1;
        #1;
        chk("mrst_during_ifv", ifu_req_valid, 0);
        next();
        rst = 1'b0;
        #1;
        chk("mrst_ifu_valid", ifu_req_valid, 1);
        chk("mrst_minstret",  minstret, 0);
        chk("mrst_halted",    halted, 0);

        // MemWr and MemtoReg both set: treated as a store
        dec_MemWr = 1'b1; dec_MemtoReg = 1'b1; dec_RegWr = 1'b1;
        lsu_rvalid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c == 3) chk("both_wen", lsu_req_wen, 1);
            if (c == 5) chk("both_rf_we", rf_we, 1);
            if (c == 5) chk("both_retire", retire, 1);
            next();
        end
        #1;
        chk("both_minstret1", minstret, 1);

        // minstret wraps mod 16
        dec_MemWr = 1'b0; dec_MemtoReg = 1'b0;
        repeat (56) next();
        #1;
        chk("wrap_minstret15", minstret, 15);
        repeat (4) next();
        #1;
        chk("wrap_minstret0", minstret, 0);

        // 4: illegal beats ebreak; halt is sticky
        dec_illegal = 1'b1; dec_ebreak = 1'b1;
        repeat (3) next();
        #1;
        chk("ill_halted",   halted, 1);
        chk("ill_err",      err_code, 1);
        chk("ill_retire",   retire, 0);
        chk("ill_minstret", minstret, 0);
        for (int c = 0; c < 100; c++) begin
            next();
            #1;
            chk("hold_halted",    halted, 1);
            chk("hold_err",       err_code, 1);
            chk("hold_ifu_valid", ifu_req_valid, 0);
            chk("hold_retire",    retire, 0);
        end
        chk("hold_minstret", minstret, 0);

        // 5: IFU timeout after 8 cycles in IF_REQ
        dec_illegal = 1'b0; dec_ebreak = 1'b0;
        rst = 1'b1;
        next();
        rst = 1'b0;
        ifu_req_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("ito_ifu_valid", ifu_req_valid, 1);
            chk("ito_halted",    halted, 0);
            next();
        end
        #1;
        chk("ito_halt",      halted, 1);
        chk("ito_err",       err_code, 2);
        chk("ito_ifu_drop",  ifu_req_valid, 0);

        // ready on the last allowed cycle wins over the timeout
        rst = 1'b1;
        next();
        rst = 1'b0;
        ifu_rvalid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            ifu_req_ready = (c == 7);
            #1;
            chk("ilast_ifu_valid", ifu_req_valid, 1);
            next();
        end
        ifu_rvalid = 1'b1;
        #1;
        chk("ilast_halted",  halted, 0);
        chk("ilast_inst_we", inst_we, 1);
        chk("ilast_ifv",     ifu_req_valid, 0);

        // LSU timeout after 8 cycles in MEM_REQ
        rst = 1'b1;
        next();
        rst = 1'b0;
        ifu_req_ready = 1'b1; ifu_rvalid = 1'b1;
        dec_MemtoReg = 1'b1; lsu_req_ready = 1'b0;
        repeat (3) next();
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("lto_lsu_valid", lsu_req_valid, 1);
            next();
        end
        #1;
        chk("lto_halt",     halted, 1);
        chk("lto_err",      err_code, 3);
        chk("lto_lsu_drop", lsu_req_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
